// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: key event codes, scancodes and prefix FSM states shared by the PS/2 key decoder
package ps2_key_pkg;
  typedef enum logic [2:0] {
    KEY_LEFT     = 3'd0,
    KEY_RIGHT    = 3'd1,
    KEY_DOWN     = 3'd2,
    KEY_ROTATE   = 3'd3,
    KEY_DROP     = 3'd4,
    KEY_NEW_GAME = 3'd5
  } key_t;
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;
  typedef struct packed {
    logic hit;
    key_t key;
  } key_hit_t;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_ROTATE   = 8'h75;
  localparam logic [7:0] SC_DROP     = 8'h29;
  localparam logic [7:0] SC_NEW_GAME = 8'h76;
  // The same byte means different keys with and without the E0 prefix
  function automatic key_hit_t key_map(input logic ext, input logic [7:0] sc);
    key_hit_t r;
    r.hit = 1'b1;
    r.key = KEY_LEFT;
    if (ext)
      case (sc)
        SC_LEFT:   r.key = KEY_LEFT;
        SC_RIGHT:  r.key = KEY_RIGHT;
        SC_DOWN:   r.key = KEY_DOWN;
        SC_ROTATE: r.key = KEY_ROTATE;
        default:   r.hit = 1'b0;
      endcase
    else
      case (sc)
        SC_DROP:     r.key = KEY_DROP;
        SC_NEW_GAME: r.key = KEY_NEW_GAME;
        default:     r.hit = 1'b0;
      endcase
    return r;
  endfunction
endpackage

// File: rtl/ps2_key_repeat.sv
// ps2_key_repeat: single auto-repeat slot; fire holds at the terminal count until the event is accepted
module ps2_key_repeat
  import ps2_key_pkg::*;
#(
  parameter int DELAY  = 8_000_000,
  parameter int PERIOD = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  key_t key,
  input  logic disarm,
  input  logic stall,
  output logic fire,
  output key_t fire_key
);
  localparam int CW = $clog2(DELAY > PERIOD ? DELAY : PERIOD) + 1;
  logic armed, first;
  logic [CW-1:0] cnt;
  assign fire = armed && cnt == (first ? CW'(DELAY - 1) : CW'(PERIOD - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed    <= 1'b0;
      first    <= 1'b0;
      cnt      <= '0;
      fire_key <= KEY_LEFT;
    end else if (arm) begin
      armed    <= 1'b1;
      first    <= 1'b1;
      cnt      <= '0;
      fire_key <= key;
    end else if (disarm) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (fire) begin
      if (!stall) begin
        first <= 1'b0;
        cnt   <= '0;
      end
    end else if (armed)
      cnt <= cnt + 1'b1;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 scancode bytes into Tetris key events with movement-key auto-repeat
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int REPEAT_DELAY_TICKS   = 8_000_000,
  parameter int REPEAT_PERIOD_TICKS  = 2_500_000,
  parameter int PREFIX_TIMEOUT_TICKS = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] ps2_data_i,
  input  logic       ps2_data_en_i,
  output logic [2:0] key_o,
  output logic       key_valid_o,
  input  logic       key_ready_i,
  output logic [5:0] held_o,
  output logic [7:0] drop_cnt_o
);
  localparam int TW = $clog2(PREFIX_TIMEOUT_TICKS) + 1;
  state_t state, state_nxt;
  logic [TW-1:0] tcnt;
  logic is_make, is_brk, is_ext;
  logic make_hit, brk_hit, new_make, can_load, load_make, load_rep, rep_fire;
  key_hit_t hit;
  key_t rep_key;
  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    is_ext    = 1'b0;
    if (ps2_data_en_i)
      case (state)
        ST_IDLE: begin
          state_nxt = ps2_data_i == SC_EXT ? ST_EXT : ps2_data_i == SC_BRK ? ST_BRK : ST_IDLE;
          is_make   = ps2_data_i != SC_EXT && ps2_data_i != SC_BRK;
        end
        ST_EXT: begin
          state_nxt = ps2_data_i == SC_BRK ? ST_EXT_BRK : ps2_data_i == SC_EXT ? ST_EXT : ST_IDLE;
          is_make   = ps2_data_i != SC_EXT && ps2_data_i != SC_BRK;
          is_ext    = 1'b1;
        end
        ST_BRK: begin
          state_nxt = ST_IDLE;
          is_brk    = 1'b1;
        end
        default: begin
          state_nxt = ST_IDLE;
          is_brk    = 1'b1;
          is_ext    = 1'b1;
        end
      endcase
    else if (state != ST_IDLE && tcnt == TW'(PREFIX_TIMEOUT_TICKS - 1))
      state_nxt = ST_IDLE;
  end
  assign hit       = key_map(is_ext, ps2_data_i);
  assign make_hit  = is_make && hit.hit;
  assign brk_hit   = is_brk && hit.hit;
  assign new_make  = make_hit && !held_o[hit.key];
  assign can_load  = !key_valid_o || key_ready_i;
  assign load_make = new_make && can_load;
  // A fresh make always wins the output register over a pending repeat
  assign load_rep  = rep_fire && can_load && !new_make;
  ps2_key_repeat #(
    .DELAY (REPEAT_DELAY_TICKS),
    .PERIOD(REPEAT_PERIOD_TICKS)
  ) u_repeat (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .arm     (new_make && hit.key inside {KEY_LEFT, KEY_RIGHT, KEY_DOWN}),
    .key     (hit.key),
    .disarm  (brk_hit && hit.key == rep_key),
    .stall   (!load_rep),
    .fire    (rep_fire),
    .fire_key(rep_key)
  );
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= ps2_data_en_i || state == ST_IDLE ? '0 : tcnt + 1'b1;
    end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      key_o       <= '0;
      key_valid_o <= 1'b0;
      held_o      <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (load_make || load_rep) begin
        key_o       <= load_make ? hit.key : rep_key;
        key_valid_o <= 1'b1;
      end else if (key_ready_i)
        key_valid_o <= 1'b0;
      if (make_hit)
        held_o[hit.key] <= 1'b1;
      else if (brk_hit)
        held_o[hit.key] <= 1'b0;
      if (new_make && !can_load && drop_cnt_o != 8'hFF)
        drop_cnt_o <= drop_cnt_o + 8'd1;
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed vector table, corner-case sequences and random traffic against a timestamp model
module tb_ps2_key_decoder;
  localparam int DLY = 20, PER = 5, TMO = 16;
  logic CLOCK_50 = 0, rst_n = 1, ps2_en = 0, ready = 0;
  logic [7:0] ps2_data = 0;
  logic [2:0] key;
  logic key_valid;
  logic [5:0] held;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;
  always #5 CLOCK_50 = ~CLOCK_50;
  ps2_key_decoder #(
    .REPEAT_DELAY_TICKS  (DLY),
    .REPEAT_PERIOD_TICKS (PER),
    .PREFIX_TIMEOUT_TICKS(TMO)
  ) dut (
    .clk_i        (CLOCK_50),
    .rst_n_i      (rst_n),
    .ps2_data_i   (ps2_data),
    .ps2_data_en_i(ps2_en),
    .key_o        (key),
    .key_valid_o  (key_valid),
    .key_ready_i  (ready),
    .held_o       (held),
    .drop_cnt_o   (drop_cnt)
  );
  bit m_valid, m_ext, m_brk, m_armed;
  logic [2:0] m_key;
  logic [5:0] m_held;
  int m_drop, m_track, m_next, m_last, cyc;
  function automatic int kmap(input bit ext, input logic [7:0] b);
    if (ext) return b == 8'h6B ? 0 : b == 8'h74 ? 1 : b == 8'h72 ? 2 : b == 8'h75 ? 3 : -1;
    return b == 8'h29 ? 4 : b == 8'h76 ? 5 : -1;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_key = 0; m_held = 0; m_drop = 0; m_ext = 0; m_brk = 0;
    m_armed = 0; m_track = 0; m_next = 0; m_last = -1000000; cyc = 0;
  endtask
  // Repeats are tracked as absolute due times; a due repeat stays due until it is loaded
  task automatic model_edge();
    bit can_load, rep_due, newev, touched, load;
    int k, old_track;
    logic [2:0] lk;
    can_load = !m_valid || ready;
    rep_due = m_armed && cyc >= m_next;
    old_track = m_track;
    newev = 0; touched = 0; load = 0; lk = 0;
    if (ps2_en) begin
      if (cyc - m_last > TMO) begin m_ext = 0; m_brk = 0; end
      m_last = cyc;
      if (m_brk) begin
        k = kmap(m_ext, ps2_data);
        if (k >= 0) begin
          m_held[k] = 0;
          if (m_armed && m_track == k) begin m_armed = 0; touched = 1; end
        end
        m_ext = 0; m_brk = 0;
      end else if (ps2_data == 8'hF0) m_brk = 1;
      else if (ps2_data == 8'hE0) m_ext = 1;
      else begin
        k = kmap(m_ext, ps2_data);
        if (k >= 0 && !m_held[k]) begin
          newev = 1;
          m_held[k] = 1;
          if (can_load) begin load = 1; lk = 3'(k); end
          else if (m_drop < 255) m_drop++;
          if (k <= 2) begin m_armed = 1; m_track = k; m_next = cyc + DLY; touched = 1; end
        end
        m_ext = 0; m_brk = 0;
      end
    end
    if (rep_due && !newev && can_load) begin
      load = 1;
      lk = 3'(old_track);
      if (!touched) m_next = cyc + PER;
    end
    if (load) begin m_valid = 1; m_key = lk; end
    else if (ready) m_valid = 0;
    cyc++;
  endtask
  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    chk("model_valid", key_valid, m_valid);
    chk("model_key", key, m_key);
    chk("model_held", held, m_held);
    chk("model_drop", drop_cnt, m_drop[7:0]);
  endtask
  task automatic send(input logic [7:0] b);
    ps2_en = 1; ps2_data = b;
    step();
    ps2_en = 0;
  endtask
  typedef struct {
    logic en; logic [7:0] d; logic rdy;
    logic v; logic [2:0] k; logic [5:0] h; logic [7:0] dc;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic en, input logic [7:0] d, input logic rdy,
                     input logic v, input logic [2:0] k, input logic [5:0] h, input logic [7:0] dc);
    vec_t r;
    r.en = en; r.d = d; r.rdy = rdy; r.v = v; r.k = k; r.h = h; r.dc = dc;
    tbl.push_back(r);
  endtask
  function automatic logic [7:0] pick();
    case ($urandom_range(0, 11))
      0, 1:    return 8'hE0;
      2, 3:    return 8'hF0;
      4:       return 8'h6B;
      5:       return 8'h74;
      6:       return 8'h72;
      7:       return 8'h75;
      8:       return 8'h29;
      9:       return 8'h76;
      10:      return 8'hE1;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction
  initial begin
    logic [63:0] seen, want;
    int n;
    #2 rst_n = 0;
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    chk("rst_valid", key_valid, 0); chk("rst_key", key, 0);
    chk("rst_held", held, 0); chk("rst_drop", drop_cnt, 0);
    #2 rst_n = 1;
    model_reset();
    ready = 1;
    step();
    add(1, 8'hE0, 1, 0, 0, 6'h00, 0); add(1, 8'h6B, 1, 1, 0, 6'h01, 0);
    add(0, 8'h00, 1, 0, 0, 6'h01, 0); add(1, 8'hE0, 1, 0, 0, 6'h01, 0);
    add(1, 8'hF0, 1, 0, 0, 6'h01, 0); add(1, 8'h6B, 1, 0, 0, 6'h00, 0);
    add(1, 8'h29, 1, 1, 4, 6'h10, 0); add(1, 8'h29, 1, 0, 0, 6'h10, 0);
    add(1, 8'h29, 1, 0, 0, 6'h10, 0); add(1, 8'hF0, 1, 0, 0, 6'h10, 0);
    add(1, 8'h29, 1, 0, 0, 6'h00, 0);
    add(1, 8'h76, 0, 1, 5, 6'h20, 0); add(1, 8'h29, 0, 1, 5, 6'h30, 1);
    add(0, 8'h00, 0, 1, 5, 6'h30, 1); add(0, 8'h00, 1, 0, 0, 6'h30, 1);
    add(1, 8'hF0, 1, 0, 0, 6'h30, 1); add(1, 8'h76, 1, 0, 0, 6'h10, 1);
    add(1, 8'hF0, 1, 0, 0, 6'h10, 1); add(1, 8'h29, 1, 0, 0, 6'h00, 1);
    add(1, 8'h76, 1, 1, 5, 6'h20, 1); add(1, 8'hE0, 1, 0, 0, 6'h20, 1);
    add(1, 8'h75, 0, 1, 3, 6'h28, 1); add(1, 8'hF0, 0, 1, 3, 6'h28, 1);
    add(1, 8'h76, 1, 0, 0, 6'h08, 1); add(1, 8'hE0, 1, 0, 0, 6'h08, 1);
    add(1, 8'hF0, 1, 0, 0, 6'h08, 1); add(1, 8'h75, 1, 0, 0, 6'h00, 1);
    add(1, 8'h76, 1, 1, 5, 6'h20, 1); add(1, 8'h29, 1, 1, 4, 6'h30, 1);
    add(0, 8'h00, 1, 0, 0, 6'h30, 1); add(1, 8'hF0, 1, 0, 0, 6'h30, 1);
    add(1, 8'h76, 1, 0, 0, 6'h10, 1); add(1, 8'hF0, 1, 0, 0, 6'h10, 1);
    add(1, 8'h29, 1, 0, 0, 6'h00, 1);
    foreach (tbl[i]) begin
      ps2_en = tbl[i].en; ps2_data = tbl[i].d; ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), key_valid, tbl[i].v);
      if (tbl[i].v) chk($sformatf("tbl%0d_key", i), key, tbl[i].k);
      chk($sformatf("tbl%0d_held", i), held, tbl[i].h);
      chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].dc);
    end
    ps2_en = 0; ready = 1;
    step();
    send(8'hE0);
    repeat (TMO + 1) step();
    send(8'h75);
    chk("tmo_expired_valid", key_valid, 0);
    chk("tmo_expired_held", held[3], 0);
    send(8'hE0);
    repeat (TMO - 1) step();
    send(8'h75);
    chk("tmo_inside_valid", key_valid, 1);
    chk("tmo_inside_key", key, 3);
    chk("tmo_inside_held", held[3], 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    step();
    seen = 0;
    want = 0;
    want[1] = 1; want[21] = 1; want[26] = 1; want[31] = 1; want[36] = 1;
    send(8'hE0);
    send(8'h74);
    if (key_valid && key == 3'd1) seen[1] = 1;
    for (int o = 2; o <= 40; o++) begin
      step();
      if (key_valid && key == 3'd1) seen[o] = 1;
    end
    chk("repeat_offsets", seen[40:0], want[40:0]);
    send(8'hE0); send(8'hF0); send(8'h74);
    n = 0;
    repeat (30) begin step(); if (key_valid) n++; end
    chk("repeat_after_break", n, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        ps2_en = 0;
        repeat (TMO + 2) step();
      end
      ps2_en = ($urandom_range(0, 2) == 0);
      ps2_data = pick();
      ready = ($urandom_range(0, 3) != 0);
      step();
    end
    ps2_en = 0; ready = 1;
    repeat (TMO + 2) step();
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h29); send(8'hF0); send(8'h76);
    repeat (3) step();
    chk("clean_held", held, 0);
    chk("clean_valid", key_valid, 0);
    ready = 0;
    send(8'h29);
    for (int i = 0; i < 300; i++) begin send(8'hF0); send(8'h29); send(8'h29); end
    chk("drop_saturated", drop_cnt, 8'hFF);
    chk("drop_key_held", key, 4);
    ready = 1;
    step();
    send(8'hF0); send(8'h29);
    step();
    send(8'hE0);
    send(8'h72);
    ready = 0;
    repeat (25) step();
    chk("pre_rst_valid", key_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", key_valid, 0); chk("arst_key", key, 0);
    chk("arst_held", held, 0); chk("arst_drop", drop_cnt, 0);
    @(posedge CLOCK_50); @(posedge CLOCK_50);
    #3 rst_n = 1;
    model_reset();
    ready = 1;
    n = 0;
    repeat (40) begin step(); if (key_valid) n++; end
    chk("post_rst_no_repeat", n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the raw PS/2 byte stream from the PS/2 controller into discrete Tetris key events, with hardware auto-repeat for the movement keys. It sits between `PS2_Controller` and `user_input` in the 50 MHz domain. It consumes `received_data`/`received_data_en` and produces one key event per handshake through a single-entry output register. Its held-key vector and drop counter are exported for debug.

## Interface
Parameters:
- `REPEAT_DELAY_TICKS`, default 8_000_000: clocks from make to the first auto-repeat (160 ms at 50 MHz).
- `REPEAT_PERIOD_TICKS`, default 2_500_000: clocks between subsequent repeats (50 ms).
- `PREFIX_TIMEOUT_TICKS`, default 1_000_000: clocks a prefix state may wait for its next byte.

Ports:
- `clk_i` in 1: single clock; the whole block runs on it.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `ps2_data_i` in 8: received scancode byte.
- `ps2_data_en_i` in 1: one-cycle strobe; `ps2_data_i` is valid in that cycle.
- `key_o` out 3: `key_t` event code.
- `key_valid_o` out 1: `key_o` holds an undelivered event.
- `key_ready_i` in 1: consumer accepts the event this cycle.
- `held_o` out 6: one bit per `key_t`, set while the key is physically down.
- `drop_cnt_o` out 8: saturating count of dropped make events.

## Operation
- `key_t` encoding:
  - 0 LEFT (E0 6B), 1 RIGHT (E0 74), 2 DOWN (E0 72), 3 ROTATE (E0 75), 4 DROP (29), 5 NEW_GAME (76).
  - All other codes are ignored.
- Prefix FSM, advanced only on `ps2_data_en_i`:
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a normal make, stay IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte is an extended make, then IDLE.
  - BRK: any byte is a normal break, then IDLE.
  - EXT_BRK: any byte is an extended break, then IDLE.
  - In EXT, BRK or EXT_BRK: after `PREFIX_TIMEOUT_TICKS` clocks with no strobe, return to IDLE with no action. The timeout counter resets on every strobe.
- Make of a mapped key:
  - If its `held_o` bit is clear: set the bit and emit an event.
  - If the bit is already set (keyboard typematic): no event.
- Break of a mapped key clears its `held_o` bit and emits no event.
- Unmapped keys never touch `held_o`; the FSM still sequences over them, so E1 pause sequences are harmless.
- Auto-repeat for LEFT/RIGHT/DOWN:
  - One repeat slot tracks the most recently made repeatable key; a new repeatable make retargets the slot and restarts the counter at 0.
  - The first repeat fires at count `REPEAT_DELAY_TICKS`-1; subsequent repeats fire every `REPEAT_PERIOD_TICKS`.
  - A break of the tracked key disarms the slot. A break of any other key does not affect it.
- Output register:
  - Loads when it is empty, or when it is being consumed in the same cycle (valid && ready).
  - Transfer occurs on `key_valid_o && key_ready_i`.
- Arbitration:
  - A byte-generated make beats a repeat fired in the same cycle.
  - A repeat that cannot load holds its counter at the terminal value and retries every cycle, so repeats are never lost.
  - A make that cannot load is dropped: `held_o` is still updated and `drop_cnt_o` increments, saturating at 255.
- Reset: all state returns to its reset value, including mid-prefix and mid-repeat.

## Timing
- Reset values: `key_o`=0, `key_valid_o`=0, `held_o`=0, `drop_cnt_o`=0, FSM IDLE, repeat slot disarmed, all counters 0.
- Latency: a strobe in cycle N produces `key_valid_o`=1 with the new `key_o` in cycle N+1; `held_o` also updates at N+1.
- `key_valid_o` stays high and `key_o` stays stable until a transfer.
- Back-to-back transfers are legal: a consumed slot can be refilled in the same cycle, so a new event appears at N+1 with no bubble.
- Repeat: first event at make+`REPEAT_DELAY_TICKS`+1 cycles, then one every `REPEAT_PERIOD_TICKS` cycles while unstalled.

## Structure
- Package `ps2_key_pkg` holds:
  - `key_t` enum (3 bits);
  - scancode localparams: `SC_EXT`=E0, `SC_BRK`=F0, and the six key codes;
  - FSM state enum.
- Sub-module `ps2_key_repeat` holds the repeat slot, its counter and its stall logic.
  - Inputs: arm/key/disarm/stall.
  - Outputs: fire/key.

## Test plan
- Send E0 6B with `key_ready_i`=1 → one LEFT event one cycle after the 6B strobe; `held_o[0]`=1. Then send E0 F0 6B → `held_o[0]`=0, no event.
- Send 29 three times (typematic) → exactly one DROP event. Then send F0 29 → `held_o[4]`=0.
- With `REPEAT_DELAY_TICKS`=20 and `REPEAT_PERIOD_TICKS`=5, hold RIGHT for 40 cycles → events at offsets 1, 21, 26, 31, 36. Break RIGHT → no further events.
- Hold `key_ready_i`=0 and send makes for 76 then 29 → `key_o`=NEW_GAME is held; `drop_cnt_o`=1; `held_o[4]`=1.
- Send E0, then wait `PREFIX_TIMEOUT_TICKS`+1 cycles, then send 75 → no ROTATE event (75 is treated as a normal, unmapped make).
- Deassert `rst_n_i` while DOWN is repeating and `key_valid_o`=1 → all outputs reset to 0 asynchronously. After reset is released, no repeat events occur.
